// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte image from the UART RX, assembles
// big-endian 32-bit words, writes them into instruction memory and keeps
// the CPU in reset until the whole image has passed its checksum.
//
// Byte handshake: a byte is consumed on a rising clk edge where
// rx_valid && rx_ready; rx_ready depends only on the current state, and
// bytes offered while rx_ready=0 stay with the sender untouched.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64,
  parameter int          TIMEOUT   = 1_000_000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] ram_a,
  output logic [31:0] d_t_ram,
  output logic        wram,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_W_SETUP,
    S_W_STROBE, S_W_HOLD, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [15:0]     DEPTH_W  = 16'(DEPTH);

  state_t          state_q, state_d;
  logic [7:0]      sum_q, sum_d;
  logic [7:0]      len_hi_q, len_hi_d;
  logic [15:0]     len_q, len_d;
  logic [23:0]     word_q, word_d;
  logic [1:0]      bidx_q, bidx_d;
  logic [15:0]     widx_q, widx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [31:0]     ram_a_q, ram_a_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      err_code_q, err_code_d;

  logic            accept;
  logic            start_ok;
  logic            tmo;
  logic [15:0]     len_n;
  logic            len_bad;
  logic [7:0]      sum_next;
  logic [15:0]     widx_inc;

  assign accept   = rx_valid & rx_ready;
  assign start_ok = start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERR));
  assign tmo      = (timer_q == TMO_LAST);
  assign len_n    = {len_hi_q, rx_data};
  assign len_bad  = (len_n == 16'd0) | (len_n > DEPTH_W);
  assign sum_next = sum_q + rx_data;
  assign widx_inc = widx_q + 16'd1;

  // State register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; an accepted byte always beats a timeout in the same cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (accept)   state_d = S_LEN_LO;
        else if (tmo) state_d = S_ERR;
      end
      S_LEN_LO: begin
        if (accept)   state_d = len_bad ? S_ERR : S_DATA;
        else if (tmo) state_d = S_ERR;
      end
      S_DATA: begin
        if (accept)   state_d = (bidx_q == 2'd3) ? S_W_SETUP : S_DATA;
        else if (tmo) state_d = S_ERR;
      end
      S_W_SETUP:  state_d = S_W_STROBE;
      S_W_STROBE: state_d = S_W_HOLD;
      S_W_HOLD:   state_d = (widx_inc < len_q) ? S_DATA : S_CSUM;
      S_CSUM: begin
        if (accept)   state_d = (sum_next == 8'd0) ? S_DONE : S_ERR;
        else if (tmo) state_d = S_ERR;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  // Output decode: everything except the write bus and error code follows the state
  always_comb begin
    rx_ready  = (state_q == S_LEN_HI) | (state_q == S_LEN_LO) |
                (state_q == S_DATA)   | (state_q == S_CSUM);
    wram      = (state_q == S_W_STROBE);
    busy      = rx_ready | (state_q == S_W_SETUP) | (state_q == S_W_STROBE) |
                (state_q == S_W_HOLD);
    done      = (state_q == S_DONE);
    err       = (state_q == S_ERR);
    cpu_hold  = busy | err;
    err_code  = err_code_q;
    ram_a     = ram_a_q;
    d_t_ram   = wdata_q;
    dbg_state = state_q;
  end

  // Datapath next values: checksum, length, word assembly, indices, timer, write bus
  always_comb begin
    sum_d      = sum_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    word_d     = word_q;
    bidx_d     = bidx_q;
    widx_d     = widx_q;
    timer_d    = timer_q;
    ram_a_d    = ram_a_q;
    wdata_d    = wdata_q;
    err_code_d = err_code_q;
    if (start_ok) begin
      sum_d      = 8'd0;
      bidx_d     = 2'd0;
      widx_d     = 16'd0;
      timer_d    = '0;
      err_code_d = 2'd0;
    end else if (rx_ready) begin
      if (accept) begin
        sum_d   = sum_next;
        timer_d = '0;
        unique case (state_q)
          S_LEN_HI: len_hi_d = rx_data;
          S_LEN_LO: begin
            len_d = len_n;
            if (len_bad) err_code_d = 2'd1;
          end
          S_DATA: begin
            word_d = {word_q[15:0], rx_data};
            bidx_d = bidx_q + 2'd1;
            // The bus is loaded on entry to W_SETUP so it is stable before the strobe
            if (bidx_q == 2'd3) begin
              ram_a_d = BASE_ADDR + 32'({widx_q, 2'b00});
              wdata_d = {word_q, rx_data};
            end
          end
          S_CSUM:   if (sum_next != 8'd0) err_code_d = 2'd2;
          default:  ;
        endcase
      end else if (tmo) begin
        err_code_d = 2'd3;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end else if (state_q == S_W_HOLD) begin
      widx_d = widx_inc;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sum_q      <= 8'd0;
      len_hi_q   <= 8'd0;
      len_q      <= 16'd0;
      word_q     <= 24'd0;
      bidx_q     <= 2'd0;
      widx_q     <= 16'd0;
      timer_q    <= '0;
      ram_a_q    <= BASE_ADDR;
      wdata_q    <= 32'd0;
      err_code_q <= 2'd0;
    end else begin
      sum_q      <= sum_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      word_q     <= word_d;
      bidx_q     <= bidx_d;
      widx_q     <= widx_d;
      timer_q    <= timer_d;
      ram_a_q    <= ram_a_d;
      wdata_q    <= wdata_d;
      err_code_q <= err_code_d;
    end
  end

endmodule
